// File: rtl/key_event_rx_if.sv
// Key event bundle: raw active-low KEY lines in, debounced level and
// one-cycle press/release pulses out. The producer of KEY (board pins or a
// bench) takes the master side; key_event_rx takes the slave side.
interface key_event_rx_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;

  modport master (
    output KEY,
    input  key_down,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  KEY,
    output key_down,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_event_rx.sv
// key_event_rx: push-button receiver. Each raw active-low KEY line goes
// through a 2-flop synchroniser, is inverted to an active-high sample and is
// debounced by its own IDLE/ARMING/HELD/DISARMING FSM. Accepted changes give
// a clean key_down level plus one-cycle key_press / key_release pulses.
// Optional build macro: KEY_REPEAT_EN adds auto-repeat press pulses while a
// key stays held (REPEAT_DELAY to the first repeat, then every
// REPEAT_PERIOD). Without the macro no repeat logic exists.
module key_event_rx #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic          CLOCK_50,
  input  logic          reset_n,
  key_event_rx_if.slave kif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REPEAT_PERIOD - 1);
  localparam logic [REP_W-1:0] REP_SAT      = REP_W'(REP_MAX);
`endif

  // Parameters outside their legal range make the debounce/repeat timing
  // meaningless, so refuse to elaborate.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_event_rx: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    DISARMING = 2'd3
  } state_e;

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] ks;
  logic [N_KEYS-1:0] down_v;
  logic [N_KEYS-1:0] press_v;
  logic [N_KEYS-1:0] release_v;

  // Synchroniser next-state: first stage samples the asynchronous pins,
  // second stage re-times the first.
  always_comb begin
    sync1_d = kif.KEY;
    sync2_d = sync1_q;
  end

  // Synchroniser flops reset to 1 so every key looks released after reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Active-high pressed sample seen by the debounce FSMs.
  assign ks = ~sync2_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             down_q;
    logic             press_q;
    logic             release_q;

    // Saturating increment of the debounce window counter.
    always_comb begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

`ifdef KEY_REPEAT_EN
    logic [REP_W-1:0] rcnt_q;
    logic [REP_W-1:0] rcnt_inc;
    logic             rfirst_q;
    logic             rep_hit;

    // Repeat timing: before the first repeat the counter measures
    // REPEAT_DELAY from the press, afterwards REPEAT_PERIOD between repeats.
    always_comb begin
      rcnt_inc = (rcnt_q == REP_SAT) ? rcnt_q : rcnt_q + REP_W'(1);
      rep_hit  = rfirst_q ? (rcnt_q == REP_PER_LAST) : (rcnt_q == REP_DLY_LAST);
    end
`endif

    // Debounce FSM with registered level and event pulses. Any sample that
    // disagrees with the window being timed sends the FSM back and discards
    // the partial count.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        down_q    <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
        rcnt_q    <= '0;
        rfirst_q  <= 1'b0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
        // While the key is accepted as down (HELD or DISARMING) the repeat
        // counter keeps running; a release below overrides this.
        if (down_q) begin
          if (rep_hit) begin
            rcnt_q   <= '0;
            rfirst_q <= 1'b1;
            press_q  <= 1'b1;
          end else begin
            rcnt_q <= rcnt_inc;
          end
        end
`endif
        unique case (state_q)
          IDLE: begin
            if (ks[k]) begin
              if (DEBOUNCE_CYCLES == 1) begin
                // A one-sample window accepts the press immediately.
                state_q <= HELD;
                cnt_q   <= '0;
                down_q  <= 1'b1;
                press_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                rcnt_q   <= '0;
                rfirst_q <= 1'b0;
`endif
              end else begin
                state_q <= ARMING;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          ARMING: begin
            if (!ks[k]) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q >= CNT_LAST) begin
              state_q <= HELD;
              cnt_q   <= '0;
              down_q  <= 1'b1;
              press_q <= 1'b1;
`ifdef KEY_REPEAT_EN
              rcnt_q   <= '0;
              rfirst_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          HELD: begin
            if (!ks[k]) begin
              if (DEBOUNCE_CYCLES == 1) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                down_q    <= 1'b0;
                release_q <= 1'b1;
                press_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
                rcnt_q   <= '0;
                rfirst_q <= 1'b0;
`endif
              end else begin
                state_q <= DISARMING;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
          DISARMING: begin
            if (ks[k]) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q >= CNT_LAST) begin
              // Release wins over a coinciding repeat so press and release
              // never pulse together.
              state_q   <= IDLE;
              cnt_q     <= '0;
              down_q    <= 1'b0;
              release_q <= 1'b1;
              press_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
              rcnt_q   <= '0;
              rfirst_q <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign down_v[k]    = down_q;
    assign press_v[k]   = press_q;
    assign release_v[k] = release_q;
  end

  assign kif.key_down    = down_v;
  assign kif.key_press   = press_v;
  assign kif.key_release = release_v;

endmodule

// File: tb/tb_key_event_rx.sv
// Bench for key_event_rx (DEBOUNCE_CYCLES=5, REPEAT_DELAY=20, REPEAT_PERIOD=8).
// Reference model: per key, the synchronised sample stream is compared with
// the accepted level; a run of DEBOUNCE_CYCLES consecutive disagreeing
// samples flips the level and fires a pulse. With KEY_REPEAT_EN the age of
// the accepted press decides repeat pulses arithmetically.
module tb_key_event_rx;

  localparam int N   = 4;
  localparam int DB  = 5;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic clk;
  logic rst_n;

  key_event_rx_if #(.N_KEYS(N)) kif ();

  key_event_rx #(
    .N_KEYS          (N),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .kif      (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reference model state
  logic [N-1:0] m_s1, m_s2;
  logic [N-1:0] exp_down, exp_press, exp_rel;
  int           m_run [N];
  int           m_age [N];

  // observed event bookkeeping for directed timing checks
  int press_cnt  [N];
  int last_press [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1;
    m_s2 = '1;
    exp_down = '0;
    exp_press = '0;
    exp_rel = '0;
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0;
      m_age[k] = 0;
    end
  endtask

  task automatic model_step(input logic [N-1:0] key_now);
    for (int k = 0; k < N; k++) begin
      logic pressed;
      pressed = ~m_s2[k];
      exp_press[k] = 1'b0;
      exp_rel[k]   = 1'b0;
      if (pressed != exp_down[k]) m_run[k]++;
      else m_run[k] = 0;
      if (m_run[k] == DB) begin
        m_run[k] = 0;
        exp_down[k] = pressed;
        if (pressed) begin
          exp_press[k] = 1'b1;
          m_age[k] = 0;
        end else begin
          exp_rel[k] = 1'b1;
          m_age[k] = 0;
        end
      end else if (exp_down[k]) begin
`ifdef KEY_REPEAT_EN
        m_age[k]++;
        if (m_age[k] == RD || (m_age[k] > RD && (m_age[k] - RD) % RP == 0))
          exp_press[k] = 1'b1;
`endif
      end
    end
    m_s2 = m_s1;
    m_s1 = key_now;
  endtask

  // One clock: advance the model with the KEY value seen at the edge, then
  // compare all outputs 1 time unit later.
  task automatic tick();
    logic [N-1:0] key_smp;
    @(posedge clk);
    key_smp = kif.KEY;
    if (rst_n) model_step(key_smp);
    else model_reset();
    cyc++;
    #1;
    for (int k = 0; k < N; k++) begin
      if (kif.key_press[k] === 1'b1) begin
        press_cnt[k]++;
        last_press[k] = cyc;
      end
    end
    check("key_down",    32'(kif.key_down),    32'(exp_down));
    check("key_press",   32'(kif.key_press),   32'(exp_press));
    check("key_release", 32'(kif.key_release), 32'(exp_rel));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int c0, c1, pc, hold [N];
  logic [N-1:0] kv;

  initial begin
    for (int k = 0; k < N; k++) begin
      press_cnt[k]  = 0;
      last_press[k] = -1;
      hold[k]       = 1;
    end

    // 1. Reset with all keys held: outputs quiet, then one press per key
    //    7 edges after release (first edge after release acts as edge E).
    rst_n    = 1'b0;
    kif.KEY  = 4'b0000;
    model_reset();
    #1;
    check("reset_outs", 32'({kif.key_down, kif.key_press, kif.key_release}), 32'd0);
    ticks(3);
    check("reset_outs_held", 32'({kif.key_down, kif.key_press, kif.key_release}), 32'd0);
    rst_n = 1'b1;
    c0 = cyc;
    ticks(10);
    for (int k = 0; k < N; k++) check("reset_press_edge", 32'(last_press[k]), 32'(c0 + 7));
    check("reset_down_all", 32'(kif.key_down), 32'hF);

    kif.KEY = 4'b1111;
    ticks(10);
    check("all_released", 32'(kif.key_down), 32'h0);

    // 2. Clean press/release on KEY[0].
    kif.KEY[0] = 1'b0;
    c0 = cyc;
    pc = press_cnt[0];
    ticks(10);
    check("clean_press_edge", 32'(last_press[0]), 32'(c0 + 7));
    check("clean_press_count", 32'(press_cnt[0] - pc), 32'd1);
    kif.KEY[0] = 1'b1;
    ticks(10);
    check("clean_release_down", 32'(kif.key_down[0]), 32'd0);

    // 3. Bounce on KEY[1]: short bursts rejected, then a long hold accepted.
    pc = press_cnt[1];
    kif.KEY[1] = 1'b0; ticks(3);
    kif.KEY[1] = 1'b1; ticks(1);
    kif.KEY[1] = 1'b0; ticks(3);
    kif.KEY[1] = 1'b1; ticks(8);
    check("bounce_no_press", 32'(press_cnt[1] - pc), 32'd0);
    kif.KEY[1] = 1'b0; ticks(10);
    check("bounce_one_press", 32'(press_cnt[1] - pc), 32'd1);
    kif.KEY[1] = 1'b1; ticks(10);

    // 4. Independence: KEY[2] pressed 2 cycles after KEY[3].
    kif.KEY[3] = 1'b0;
    c0 = cyc;
    ticks(2);
    kif.KEY[2] = 1'b0;
    ticks(10);
    check("indep_key3_edge", 32'(last_press[3]), 32'(c0 + 7));
    check("indep_gap", 32'(last_press[2] - last_press[3]), 32'd2);
    kif.KEY[3:2] = 2'b11;
    ticks(10);

    // 5. Reset in the middle of an arming window.
    kif.KEY[0] = 1'b0;
    pc = press_cnt[0];
    ticks(5);
    rst_n = 1'b0;
    model_reset();
    ticks(3);
    check("midreset_no_press", 32'(press_cnt[0] - pc), 32'd0);
    rst_n = 1'b1;
    c1 = cyc;
    ticks(10);
    check("midreset_press_edge", 32'(last_press[0]), 32'(c1 + 7));
    check("midreset_press_count", 32'(press_cnt[0] - pc), 32'd1);
    kif.KEY[0] = 1'b1;
    ticks(10);

    // Randomised bouncing on all keys against the model.
    for (int i = 0; i < 600; i++) begin
      kv = kif.KEY;
      for (int k = 0; k < N; k++) begin
        hold[k]--;
        if (hold[k] <= 0) begin
          kv[k]   = ~kv[k];
          hold[k] = int'($urandom_range(1, 12));
        end
      end
      kif.KEY = kv;
      tick();
    end
    kif.KEY = 4'b1111;
    ticks(10);
    check("random_settled", 32'(kif.key_down), 32'h0);

    // 6. Long hold on KEY[0]: auto-repeat only with KEY_REPEAT_EN.
    pc = press_cnt[0];
    kif.KEY[0] = 1'b0;
    c0 = cyc;
    ticks(62);
    check("hold_first_edge_seen", 32'(last_press[0] >= c0 + 7), 32'd1);
`ifdef KEY_REPEAT_EN
    check("hold_press_count", 32'(press_cnt[0] - pc), 32'd6);
    check("hold_last_repeat", 32'(last_press[0]), 32'(c0 + 7 + 52));
`else
    check("hold_press_count", 32'(press_cnt[0] - pc), 32'd1);
    check("hold_last_press", 32'(last_press[0]), 32'(c0 + 7));
`endif
    kif.KEY[0] = 1'b1;
    ticks(10);
    check("hold_released", 32'(kif.key_down[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
